// File: rtl/int_req_arb.sv
// Interrupt request arbiter: latches source rising edges into pending bits, picks the lowest
// unmasked pending index and runs the int_req / int_srv handshake toward the SXP core.
module int_req_arb #(
  parameter int unsigned NUM_SRC  = 16,
  parameter int unsigned TO_WIDTH = 8,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic [NUM_SRC-1:0] clr_pend,
  input  logic               int_rdy,
  input  logic               int_srv_req,
  input  logic [15:0]        int_srv_num,
  output logic               int_req,
  output logic [15:0]        int_num,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned SelW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  src_q;
  logic [NUM_SRC-1:0]  pend_q, pend_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                int_req_q, int_req_d;
  logic [15:0]         int_num_q, int_num_d;
  logic                terr_q, terr_d;

  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  retire;
  logic [SelW-1:0]     arb_idx;

  always_comb begin
    rise     = src_irq & ~src_q;
    eligible = pend_q & ~src_mask;

    // Descending scan so the lowest eligible index is the one left standing.
    arb_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) arb_idx = SelW'(i);
    end

    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    retire    = '0;
    int_req_d = 1'b0;
    int_num_d = '0;
    terr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((|eligible) && int_rdy) begin
          state_d   = StReq;
          sel_d     = arb_idx;
          int_req_d = 1'b1;
          int_num_d = 16'(arb_idx);
        end
      end
      StReq: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        cnt_d = cnt_q + TO_WIDTH'(1);
        if (int_srv_req && (int_srv_num == 16'(sel_q))) begin
          retire  = NUM_SRC'(1) << sel_q;
          state_d = StIdle;
        end else if (cnt_q == TO_WIDTH'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh edge beats both software clear and retirement.
    pend_d = rise | (pend_q & ~clr_pend & ~retire);
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q   <= StIdle;
      src_q     <= '0;
      pend_q    <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      int_req_q <= 1'b0;
      int_num_q <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_irq;
      pend_q    <= pend_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      int_req_q <= int_req_d;
      int_num_q <= int_num_d;
      terr_q    <= terr_d;
    end
  end

  assign int_req     = int_req_q;
  assign int_num     = int_num_q;
  assign pending     = pend_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = terr_q;

endmodule
